// File: rtl/hex_display_pkg.sv
// Shared types and constants for the hex display controller.
//   reg_addr_e  - write-bus register map (VALUE, CTRL, BLINK, reserved)
//   ctrl_t      - the CTRL fields that are actually stored
//   digit_idx_t - scan digit index (up to 8 digits)
//   GlyphTable  - active-high g..a segment patterns for 0-F
package hex_display_pkg;

    typedef enum logic [1:0] {
        AddrValue = 2'd0,
        AddrCtrl  = 2'd1,
        AddrBlink = 2'd2,
        AddrRsvd  = 2'd3
    } reg_addr_e;

    localparam int unsigned CtrlEnableBit = 0;
    localparam int unsigned CtrlBlankBit  = 1;
    localparam int unsigned CtrlDpLsb     = 8;
    localparam int unsigned MaxDigits     = 8;

    typedef logic [2:0] digit_idx_t;

    typedef struct packed {
        logic [7:0] dp;
        logic       blank;
        logic       en;
    } ctrl_t;

    // Index 0 is the rightmost entry.
    localparam logic [15:0][6:0] GlyphTable = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    function automatic logic [6:0] glyph(input logic [3:0] nib);
        return GlyphTable[nib];
    endfunction

endpackage

// File: rtl/hex_display_ctrl_if.sv
// Register write bus of the hex display controller.
//   wr_valid/wr_ready - valid/ready handshake
//   wr_addr           - register select
//   wr_data           - write data
interface hex_display_ctrl_if;
    import hex_display_pkg::*;

    logic        wr_valid;
    logic        wr_ready;
    reg_addr_e   wr_addr;
    logic [31:0] wr_data;

    modport master (output wr_valid, output wr_addr, output wr_data, input wr_ready);
    modport slave  (input wr_valid, input wr_addr, input wr_data, output wr_ready);

endinterface

// File: rtl/display_scan_timer.sv
// Scan timing: prescaler plus digit counter.
//   clk, reset - clock, synchronous active-high reset
//   digit_o    - digit currently being scanned
//   tick_o     - last prescaler clock of a digit slot
//   frame_o    - tick on the last digit (frame boundary)
module display_scan_timer
    import hex_display_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = 8,
    parameter int unsigned SCAN_DIV   = 50000
) (
    input  logic       clk,
    input  logic       reset,
    output digit_idx_t digit_o,
    output logic       tick_o,
    output logic       frame_o
);

    localparam int unsigned PreW = $clog2(SCAN_DIV);

    logic [PreW-1:0] pre_q, pre_d;
    digit_idx_t      digit_q, digit_d;

    assign tick_o  = (pre_q == PreW'(SCAN_DIV - 1));
    assign frame_o = tick_o && (digit_q == digit_idx_t'(NUM_DIGITS - 1));
    assign digit_o = digit_q;

    always_comb begin
        pre_d   = tick_o ? '0 : pre_q + 1'b1;
        digit_d = digit_q;
        if (tick_o) begin
            digit_d = frame_o ? '0 : digit_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pre_q   <= '0;
            digit_q <= '0;
        end else begin
            pre_q   <= pre_d;
            digit_q <= digit_d;
        end
    end

endmodule

// File: rtl/hex_display_ctrl.sv
// Double-buffered, time-multiplexed common-anode seven-segment controller.
// Writes land in shadow registers and are committed to the live set only at
// frame boundaries, so a frame never mixes old and new contents.
//   clk, reset - clock, synchronous active-high reset
//   bus        - register write bus (slave side)
//   seg_n      - segments g..a, active-low
//   dp_n       - decimal point, active-low
//   an_n       - digit anodes, active-low
// Optional build macro: HEX_DISPLAY_BLINK_EN adds the per-digit BLINK mask.
module hex_display_ctrl
    import hex_display_pkg::*;
#(
    parameter int unsigned NUM_DIGITS   = 8,
    parameter int unsigned SCAN_DIV     = 50000,
    parameter int unsigned BLINK_FRAMES = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    hex_display_ctrl_if.slave     bus,
    output logic [6:0]            seg_n,
    output logic                  dp_n,
    output logic [NUM_DIGITS-1:0] an_n
);

    if (NUM_DIGITS < 1 || NUM_DIGITS > MaxDigits || SCAN_DIV < 2 || BLINK_FRAMES < 1)
    begin : g_bad_param
        $error("hex_display_ctrl: parameter out of range");
    end

    localparam logic [31:0] UsedMask = 32'((64'd1 << (4 * NUM_DIGITS)) - 64'd1);

    digit_idx_t digit;
    logic       tick, frame;

    display_scan_timer #(
        .NUM_DIGITS (NUM_DIGITS),
        .SCAN_DIV   (SCAN_DIV)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .digit_o (digit),
        .tick_o  (tick),
        .frame_o (frame)
    );

    logic [31:0] shadow_value_q, shadow_value_d, live_value_q;
    ctrl_t       shadow_ctrl_q, shadow_ctrl_d, live_ctrl_q;
    logic        pending_q, pending_d;
    logic        accept;
    // Index and live state only move on tick edges, so pins refresh the cycle after.
    logic        refresh_q;

`ifdef HEX_DISPLAY_BLINK_EN
    logic [7:0]  shadow_blink_q, shadow_blink_d, live_blink_q;
    logic [31:0] frame_cnt_q, frame_cnt_d;
    logic        phase_q, phase_d;
`endif

    assign bus.wr_ready = !pending_q;
    assign accept       = bus.wr_valid && !pending_q;

    always_comb begin
        shadow_value_d = shadow_value_q;
        shadow_ctrl_d  = shadow_ctrl_q;
`ifdef HEX_DISPLAY_BLINK_EN
        shadow_blink_d = shadow_blink_q;
`endif
        if (accept) begin
            unique case (bus.wr_addr)
                AddrValue: shadow_value_d = bus.wr_data;
                AddrCtrl: begin
                    shadow_ctrl_d.en    = bus.wr_data[CtrlEnableBit];
                    shadow_ctrl_d.blank = bus.wr_data[CtrlBlankBit];
                    shadow_ctrl_d.dp    = bus.wr_data[CtrlDpLsb +: 8];
                end
`ifdef HEX_DISPLAY_BLINK_EN
                AddrBlink: shadow_blink_d = bus.wr_data[7:0];
`else
                AddrBlink: ;
`endif
                default: ;
            endcase
        end
        // A write landing on the boundary commits immediately and never pends.
        if (frame) begin
            pending_d = 1'b0;
        end else if (accept && bus.wr_addr != AddrRsvd) begin
            pending_d = 1'b1;
        end else begin
            pending_d = pending_q;
        end
    end

`ifdef HEX_DISPLAY_BLINK_EN
    always_comb begin
        frame_cnt_d = frame_cnt_q;
        phase_d     = phase_q;
        if (frame) begin
            if (frame_cnt_q == BLINK_FRAMES - 1) begin
                frame_cnt_d = '0;
                phase_d     = !phase_q;
            end else begin
                frame_cnt_d = frame_cnt_q + 1'b1;
            end
        end
    end
`endif

    logic [31:0]           upper;
    logic                  dark;
    logic [6:0]            seg_d;
    logic                  dp_d;
    logic [NUM_DIGITS-1:0] an_d;

    always_comb begin
        // Nibbles from the current digit upward; zero means this digit is a leading zero.
        upper = (live_value_q & UsedMask) >> {digit, 2'b00};
        dark  = live_ctrl_q.blank && (digit != '0) && (upper == '0);
`ifdef HEX_DISPLAY_BLINK_EN
        if (phase_q && live_blink_q[digit]) begin
            dark = 1'b1;
        end
`endif
        seg_d = 7'h7F;
        dp_d  = 1'b1;
        an_d  = '1;
        if (live_ctrl_q.en) begin
            an_d = ~(NUM_DIGITS'(1) << digit);
            if (!dark) begin
                seg_d = ~glyph(upper[3:0]);
                dp_d  = ~live_ctrl_q.dp[digit];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shadow_value_q <= '0;
            shadow_ctrl_q  <= '0;
            live_value_q   <= '0;
            live_ctrl_q    <= '0;
            pending_q      <= 1'b0;
            refresh_q      <= 1'b0;
            seg_n          <= 7'h7F;
            dp_n           <= 1'b1;
            an_n           <= '1;
        end else begin
            shadow_value_q <= shadow_value_d;
            shadow_ctrl_q  <= shadow_ctrl_d;
            pending_q      <= pending_d;
            refresh_q      <= tick;
            if (frame) begin
                live_value_q <= shadow_value_d;
                live_ctrl_q  <= shadow_ctrl_d;
            end
            if (refresh_q) begin
                seg_n <= seg_d;
                dp_n  <= dp_d;
                an_n  <= an_d;
            end
        end
    end

`ifdef HEX_DISPLAY_BLINK_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            shadow_blink_q <= '0;
            live_blink_q   <= '0;
            frame_cnt_q    <= '0;
            phase_q        <= 1'b0;
        end else begin
            shadow_blink_q <= shadow_blink_d;
            frame_cnt_q    <= frame_cnt_d;
            phase_q        <= phase_d;
            if (frame) begin
                live_blink_q <= shadow_blink_d;
            end
        end
    end
`endif

endmodule

// File: tb/tb_hex_display_ctrl.sv
module tb_hex_display_ctrl;
    import hex_display_pkg::*;

    localparam logic [6:0] SegOff = 7'h7F;
    localparam logic [6:0] SegN0  = ~7'b0111111;
    localparam logic [6:0] SegN1  = ~7'b0000110;
    localparam logic [6:0] SegN2  = ~7'b1011011;
    localparam logic [6:0] SegN3  = ~7'b1001111;
    localparam logic [6:0] SegN4  = ~7'b1100110;
    localparam logic [6:0] SegN5  = ~7'b1101101;
    localparam logic [6:0] SegNA  = ~7'b1110111;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] seg_n;
    logic       dp_n;
    logic [3:0] an_n;

    hex_display_ctrl_if bus ();

    hex_display_ctrl #(
        .NUM_DIGITS   (4),
        .SCAN_DIV     (4),
        .BLINK_FRAMES (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .seg_n (seg_n),
        .dp_n  (dp_n),
        .an_n  (an_n)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;
    int failed = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_an(input logic [3:0] an, input string tag);
        int n = 0;
        while (an_n !== an && n < 200) begin
            cyc(1);
            n++;
        end
        check({tag, "_an"}, an_n, an);
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (bus.wr_ready !== 1'b1 && n < 200) begin
            cyc(1);
            n++;
        end
        check(tag, bus.wr_ready, 1);
    endtask

    // Holds the request until the handshake completes; reports cycles spent blocked.
    task automatic do_write(input reg_addr_e a, input logic [31:0] d, output int waited);
        bus.wr_valid = 1'b1;
        bus.wr_addr  = a;
        bus.wr_data  = d;
        waited = 0;
        while (bus.wr_ready !== 1'b1 && waited < 200) begin
            cyc(1);
            waited++;
        end
        check("write_not_stuck", waited < 200, 1);
        cyc(1);
        bus.wr_valid = 1'b0;
    endtask

    task automatic idle_dark(input int n, input string tag);
        bit bad = 0;
        for (int i = 0; i < n; i++) begin
            cyc(1);
            if (an_n !== 4'hF || seg_n !== SegOff || dp_n !== 1'b1 || bus.wr_ready !== 1'b1)
                bad = 1;
        end
        check(tag, bad, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  w;
        bit  dark [8];
        bit  lit_ok;
        bit  d1_ok;

        bus.wr_valid = 1'b0;
        bus.wr_addr  = AddrValue;
        bus.wr_data  = '0;

        // 1. Reset state, then enable=0 keeps everything dark.
        cyc(3);
        check("reset_an", an_n, 4'hF);
        check("reset_seg", seg_n, SegOff);
        check("reset_dp", dp_n, 1);
        check("reset_ready", bus.wr_ready, 1);
        reset = 1'b0;
        idle_dark(100, "idle_100");

        // 2. CTRL then VALUE; second write waits for the boundary.
        do_write(AddrCtrl, 32'h1, w);
        check("ctrl_pending", bus.wr_ready, 0);
        do_write(AddrValue, 32'h0000_1234, w);
        check("value_blocked", w > 0, 1);
        wait_ready("value_commit");
        wait_an(4'b1110, "v1234_d0");
        check("v1234_d0_seg", seg_n, SegN4);
        check("v1234_d0_dp", dp_n, 1);
        wait_an(4'b1101, "v1234_d1");
        check("v1234_d1_seg", seg_n, SegN3);
        wait_an(4'b1011, "v1234_d2");
        check("v1234_d2_seg", seg_n, SegN2);
        wait_an(4'b0111, "v1234_d3");
        check("v1234_d3_seg", seg_n, SegN1);

        // 3. Write during digit 2; old value persists through digit 3.
        wait_an(4'b1011, "slot2");
        do_write(AddrValue, 32'hA, w);
        check("va_pending", bus.wr_ready, 0);
        wait_an(4'b0111, "old_d3");
        check("old_d3_seg", seg_n, SegN1);
        do_write(AddrCtrl, 32'h1, w);
        check("second_blocked", w > 0, 1);
        wait_an(4'b1110, "va_d0");
        check("va_d0_seg", seg_n, SegNA);
        wait_an(4'b1101, "va_d1");
        check("va_d1_seg", seg_n, SegN0);

        // 4. Leading-zero blanking with a decimal point on digit 1.
        do_write(AddrCtrl, 32'h0000_0203, w);
        do_write(AddrValue, 32'h0000_0050, w);
        wait_ready("blank_commit");
        wait_an(4'b1110, "bl_d0");
        check("bl_d0_seg", seg_n, SegN0);
        check("bl_d0_dp", dp_n, 1);
        wait_an(4'b1101, "bl_d1");
        check("bl_d1_seg", seg_n, SegN5);
        check("bl_d1_dp", dp_n, 0);
        wait_an(4'b1011, "bl_d2");
        check("bl_d2_seg", seg_n, SegOff);
        check("bl_d2_dp", dp_n, 1);
        wait_an(4'b0111, "bl_d3");
        check("bl_d3_seg", seg_n, SegOff);
        check("bl_d3_dp", dp_n, 1);

        // 5. Blink mask on digit 0.
        do_write(AddrBlink, 32'h1, w);
        wait_ready("blink_commit");
        lit_ok = 1;
        d1_ok  = 1;
        for (int f = 0; f < 8; f++) begin
            wait_an(4'b1110, "blink_d0");
            dark[f] = (seg_n === SegOff) && (dp_n === 1'b1);
            if (!dark[f] && seg_n !== SegN0) lit_ok = 0;
            wait_an(4'b1101, "blink_d1");
            if (seg_n !== SegN5) d1_ok = 0;
        end
        check("blink_lit_glyph", lit_ok, 1);
        check("blink_d1_unaffected", d1_ok, 1);
`ifdef HEX_DISPLAY_BLINK_EN
        // Two frames on, two off: every frame differs from the one two later.
        for (int f = 0; f < 6; f++) begin
            check($sformatf("blink_period_%0d", f), dark[f] ^ dark[f + 2], 1);
        end
`else
        for (int f = 0; f < 8; f++) begin
            check($sformatf("noblink_lit_%0d", f), dark[f], 0);
        end
`endif

        // 6. Reset mid-slot with a pending write.
        do_write(AddrValue, 32'h7, w);
        check("pre_reset_pending", bus.wr_ready, 0);
        reset = 1'b1;
        cyc(1);
        check("midrst_an", an_n, 4'hF);
        check("midrst_seg", seg_n, SegOff);
        check("midrst_dp", dp_n, 1);
        check("midrst_ready", bus.wr_ready, 1);
        reset = 1'b0;
        idle_dark(40, "post_reset_dark");
        do_write(AddrCtrl, 32'h1, w);
        wait_ready("post_reset_commit");
        wait_an(4'b1110, "pr_d0");
        check("pr_d0_seg", seg_n, SegN0);
        wait_an(4'b1101, "pr_d1");
        check("pr_d1_seg", seg_n, SegN0);
        check("fail_count_consistent", failed, checks - passed);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
